// File: rtl/wb_writeback_ctrl.sv
// Register-file write-port arbiter: ALU results take priority and loads queue in a small FIFO.
// A per-register pending-load scoreboard lets decode see load-use hazards on rs1/rs2.
module wb_writeback_ctrl #(
  parameter int XLEN      = 32,
  parameter int LDQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            ld_pending,
  output logic            regwr,
  output logic [4:0]      rdaddr,
  output logic [XLEN-1:0] win
);

  localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam int CW = $clog2(LDQ_DEPTH + 1);

  // Handshake: a load result transfers on a posedge where ld_valid && ld_ready;
  // ld_ready is low whenever the FIFO is full or rst_n is low.
  logic [4:0]      q_rd   [LDQ_DEPTH];
  logic [XLEN-1:0] q_data [LDQ_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   occ;
  logic            full, empty, push, pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  assign full      = (occ == CW'(LDQ_DEPTH));
  assign empty     = (occ == '0);
  assign ld_ready  = rst_n && !full;
  assign push      = ld_valid && ld_ready;
  assign pop       = !alu_valid && !empty;
  assign head_rd   = q_rd[rd_ptr];
  assign head_data = q_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        q_rd[wr_ptr]   <= ld_rd;
        q_data[wr_ptr] <= ld_data;
        wr_ptr <= (wr_ptr == PW'(LDQ_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(LDQ_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwr  <= 1'b0;
      rdaddr <= '0;
      win    <= '0;
    end else if (alu_valid) begin
      regwr  <= (alu_rd != 5'd0);
      rdaddr <= alu_rd;
      win    <= alu_data;
    end else if (pop) begin
      regwr  <= (head_rd != 5'd0);
      rdaddr <= head_rd;
      win    <= head_data;
    end else begin
      regwr  <= 1'b0;
    end
  end

  // Scoreboard: a count goes up when a load is issued and down when its result reaches the write port.
  logic [1:0]  sb  [32];
  logic [31:0] inc, dec;

  always_comb begin
    inc = '0;
    dec = '0;
    if (ld_issue && ld_issue_rd != 5'd0) inc[ld_issue_rd] = 1'b1;
    if (pop && head_rd != 5'd0)          dec[head_rd]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) sb[r] <= 2'd0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc[r] && !dec[r] && sb[r] != 2'd3)
          sb[r] <= sb[r] + 2'd1;
        else if (dec[r] && !inc[r] && sb[r] != 2'd0)
          sb[r] <= sb[r] - 2'd1;
      end
    end
  end

  assign rs1_busy = (chk_rs1 != 5'd0) && (sb[chk_rs1] != 2'd0);
  assign rs2_busy = (chk_rs2 != 5'd0) && (sb[chk_rs2] != 2'd0);

  always_comb begin
    ld_pending = 1'b0;
    for (int r = 1; r < 32; r++)
      if (sb[r] != 2'd0) ld_pending = 1'b1;
  end

endmodule

// File: tb/tb_wb_writeback_ctrl.sv
// Bench for wb_writeback_ctrl: directed scenarios plus random traffic, checked every cycle
// against a queue-and-counter model of the write port, load FIFO and scoreboard.
module tb_wb_writeback_ctrl;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, ld_issue, ld_valid;
  logic [4:0]      alu_rd, ld_issue_rd, ld_rd, chk_rs1, chk_rs2;
  logic [XLEN-1:0] alu_data, ld_data;
  logic            ld_ready, rs1_busy, rs2_busy, ld_pending, regwr;
  logic [4:0]      rdaddr;
  logic [XLEN-1:0] win;

  int total = 0;
  int bad   = 0;

  wb_writeback_ctrl #(.XLEN(XLEN), .LDQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .ld_pending(ld_pending),
    .regwr(regwr), .rdaddr(rdaddr), .win(win)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model: load FIFO as a queue, scoreboard as integer counts
  logic [4:0]      exp_q_rd[$];
  logic [XLEN-1:0] exp_q[$];
  int              cnt[32];
  logic            m_regwr;
  logic [4:0]      m_rdaddr;
  logic [XLEN-1:0] m_win;
  bit              check_en = 0;

  always @(posedge clk) begin
    bit push;
    logic [4:0] r;
    if (!rst_n) begin
      m_regwr = 0; m_rdaddr = 0; m_win = 0;
      exp_q_rd.delete(); exp_q.delete();
      for (int i = 0; i < 32; i++) cnt[i] = 0;
      check_en = 1;
    end else begin
      push = ld_valid && (exp_q_rd.size() < DEPTH);
      if (alu_valid) begin
        m_regwr = (alu_rd != 0); m_rdaddr = alu_rd; m_win = alu_data;
      end else if (exp_q_rd.size() > 0) begin
        r = exp_q_rd.pop_front();
        m_win = exp_q.pop_front();
        m_rdaddr = r; m_regwr = (r != 0);
        if (r != 0 && cnt[r] > 0) cnt[r]--;
      end else begin
        m_regwr = 0;
      end
      if (ld_issue && ld_issue_rd != 0) begin
        assert (cnt[ld_issue_rd] < 3) else $error("scoreboard overflow on x%0d", ld_issue_rd);
        if (cnt[ld_issue_rd] < 3) cnt[ld_issue_rd]++;
      end
      if (push) begin
        exp_q_rd.push_back(ld_rd);
        exp_q.push_back(ld_data);
      end
    end
  end

  // compare process, mid-cycle
  always @(negedge clk) begin
    bit pend;
    if (check_en) begin
      pend = 0;
      for (int i = 1; i < 32; i++) if (cnt[i] != 0) pend = 1;
      chk("regwr", 32'(regwr), 32'(m_regwr));
      chk("rdaddr", 32'(rdaddr), 32'(m_rdaddr));
      chk("win", win, m_win);
      chk("ld_ready", 32'(ld_ready), 32'(rst_n && exp_q_rd.size() < DEPTH));
      chk("rs1_busy", 32'(rs1_busy), 32'(chk_rs1 != 0 && cnt[chk_rs1] != 0));
      chk("rs2_busy", 32'(rs2_busy), 32'(chk_rs2 != 0 && cnt[chk_rs2] != 0));
      chk("ld_pending", 32'(ld_pending), 32'(pend));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    chk_rs1 = 0; chk_rs2 = 0;
  endtask

  initial begin
    logic [4:0] got[$];
    logic [4:0] want[7];
    logic [4:0] iss_q[$];
    int k;
    bit xfer;

    // 1: reset with every input active
    rst_n = 0;
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1111_2222;
    ld_issue = 1; ld_issue_rd = 5; ld_valid = 1; ld_rd = 5; ld_data = 32'h3333_4444;
    chk_rs1 = 5; chk_rs2 = 5;
    #1;
    chk("rst_ld_ready", 32'(ld_ready), 0);
    repeat (3) step();
    chk("rst_regwr", 32'(regwr), 0);
    chk("rst_rdaddr", 32'(rdaddr), 0);
    chk("rst_win", win, 0);
    chk("rst_busy", 32'(rs1_busy | rs2_busy | ld_pending), 0);
    idle();
    rst_n = 1;
    step();

    // 2: single ALU write, then rd=0
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
    step();
    alu_valid = 0;
    chk("alu_regwr", 32'(regwr), 1);
    chk("alu_rdaddr", 32'(rdaddr), 5);
    chk("alu_win", win, 32'hDEAD_BEEF);
    step();
    chk("alu_regwr_off", 32'(regwr), 0);
    alu_valid = 1; alu_rd = 0; alu_data = 32'h0BAD_F00D;
    step();
    alu_valid = 0;
    chk("alu_x0_regwr", 32'(regwr), 0);
    step();

    // 3: load-use hazard and load writeback
    ld_issue = 1; ld_issue_rd = 7;
    step();
    ld_issue = 0; chk_rs1 = 7;
    #1;
    chk("ld_rs1_busy", 32'(rs1_busy), 1);
    chk("ld_pending_set", 32'(ld_pending), 1);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
    step();
    ld_valid = 0;
    step();
    chk("ld_regwr", 32'(regwr), 1);
    chk("ld_rdaddr", 32'(rdaddr), 7);
    chk("ld_win", win, 32'h1234);
    chk("ld_rs1_clear", 32'(rs1_busy), 0);
    step();

    // 4: ALU starves the FIFO while three loads are offered
    ld_issue = 1; ld_issue_rd = 20; step();
    ld_issue_rd = 21; step();
    ld_issue_rd = 22; step();
    ld_issue = 0;
    want = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd21, 5'd22};
    k = 0;
    for (int c = 0; c < 10; c++) begin
      alu_valid = (c < 4); alu_rd = 5'(10 + c); alu_data = 32'(c);
      ld_valid = (k < 3); ld_rd = 5'(20 + k); ld_data = 32'(32'hA0 + k);
      if (c == 2) chk("starve_ready_low", 32'(ld_ready), 0);
      xfer = ld_valid && ld_ready;
      step();
      if (xfer) k++;
      if (regwr) got.push_back(rdaddr);
    end
    idle();
    chk("starve_count", 32'(got.size()), 7);
    for (int i = 0; i < 7 && i < got.size(); i++) chk("starve_order", 32'(got[i]), 32'(want[i]));
    step();

    // 5: issue and pop of the same register in one cycle
    ld_issue = 1; ld_issue_rd = 9; chk_rs2 = 9;
    step();
    ld_issue = 0; ld_valid = 1; ld_rd = 9; ld_data = 32'h99;
    step();
    ld_valid = 0; ld_issue = 1; ld_issue_rd = 9;
    step();
    ld_issue = 0;
    #1;
    chk("same_cycle_busy", 32'(rs2_busy), 1);
    chk("same_cycle_regwr", 32'(regwr), 1);
    ld_valid = 1; ld_rd = 9; ld_data = 32'h98;
    step();
    ld_valid = 0;
    step();
    chk("same_cycle_drain", 32'(rs2_busy), 0);

    // 6: reset with a full FIFO
    ld_issue = 1; ld_issue_rd = 3; step();
    ld_issue_rd = 4; step();
    ld_issue = 0;
    alu_valid = 1; alu_rd = 1;
    ld_valid = 1; ld_rd = 3; ld_data = 32'h33; step();
    ld_rd = 4; ld_data = 32'h44; step();
    ld_valid = 0;
    chk("full_ready", 32'(ld_ready), 0);
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    chk("rst6_ready", 32'(ld_ready), 1);
    chk("rst6_pending", 32'(ld_pending), 0);
    step();
    chk("rst6_no_stale", 32'(regwr), 0);
    step();
    chk("rst6_no_stale2", 32'(regwr), 0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_rd = 5'($urandom_range(0, 31));
      alu_data = $urandom;
      ld_issue_rd = 5'($urandom_range(0, 31));
      ld_issue = ($urandom_range(0, 3) == 0) && (ld_issue_rd == 0 || cnt[ld_issue_rd] < 2);
      ld_valid = (iss_q.size() > 0) && ($urandom_range(0, 3) != 0);
      ld_rd = (iss_q.size() > 0) ? iss_q[0] : 5'd0;
      ld_data = $urandom;
      chk_rs1 = 5'($urandom_range(0, 31));
      chk_rs2 = (c % 2 == 0) ? ld_issue_rd : 5'($urandom_range(0, 31));
      if (c == 700) rst_n = 0;
      xfer = ld_valid && ld_ready;
      step();
      rst_n = 1;
      if (c == 700) iss_q.delete();
      else begin
        if (xfer) void'(iss_q.pop_front());
        if (ld_issue) iss_q.push_back(ld_issue_rd);
      end
    end
    idle();
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
